// File: rtl/dispatch_stage_pkg.sv
// Shared types for the dispatch stage: control payload and the skid-FIFO entry.
package dispatch_stage_pkg;
   localparam int N_PHYS_DEF  = 64;
   localparam int ENTRY_PW    = $clog2(N_PHYS_DEF);
   localparam int ENTRY_TAG_W = 6;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [31:0] imm;
   } ctrl_payload_t;

   typedef struct packed {
      logic [ENTRY_PW-1:0]    rs1_p;
      logic [ENTRY_PW-1:0]    rs2_p;
      logic [ENTRY_PW-1:0]    rd_new_p;
      logic [ENTRY_PW-1:0]    rd_old_p;
      logic                   rd_alloc;
      logic [ENTRY_TAG_W-1:0] rob_tag;
      ctrl_payload_t          payload;
   } dispatch_entry_t;
endpackage

// File: rtl/dispatch_stage_if.sv
// Rename -> dispatch -> ROB/IQ bus, plus writeback broadcast and recovery flush.
interface dispatch_stage_if #(
   parameter int PW        = 6,
   parameter int ROB_TAG_W = 6
);
   import dispatch_stage_pkg::*;

   logic                 ren_valid_i;
   logic                 ren_ready_o;
   logic [PW-1:0]        rs1_p_i;
   logic [PW-1:0]        rs2_p_i;
   logic [PW-1:0]        rd_new_p_i;
   logic [PW-1:0]        rd_old_p_i;
   logic                 rd_alloc_i;
   logic [ROB_TAG_W-1:0] rob_tag_i;
   ctrl_payload_t        payload_i;

   logic                 rob_valid_o;
   logic                 rob_ready_i;
   logic [ROB_TAG_W-1:0] rob_tag_o;
   logic [PW-1:0]        rob_rd_new_p_o;
   logic [PW-1:0]        rob_rd_old_p_o;
   logic                 rob_rd_alloc_o;

   logic                 iq_valid_o;
   logic                 iq_ready_i;
   logic [PW-1:0]        iq_rs1_p_o;
   logic [PW-1:0]        iq_rs2_p_o;
   logic [PW-1:0]        iq_rd_p_o;
   logic                 iq_rs1_rdy_o;
   logic                 iq_rs2_rdy_o;
   logic [ROB_TAG_W-1:0] iq_rob_tag_o;
   ctrl_payload_t        iq_payload_o;

   logic                 wb_valid_i;
   logic [PW-1:0]        wb_preg_i;
   logic                 recover_i;

   modport slave (
      input  ren_valid_i, rs1_p_i, rs2_p_i, rd_new_p_i, rd_old_p_i, rd_alloc_i,
             rob_tag_i, payload_i, rob_ready_i, iq_ready_i, wb_valid_i, wb_preg_i,
             recover_i,
      output ren_ready_o, rob_valid_o, rob_tag_o, rob_rd_new_p_o, rob_rd_old_p_o,
             rob_rd_alloc_o, iq_valid_o, iq_rs1_p_o, iq_rs2_p_o, iq_rd_p_o,
             iq_rs1_rdy_o, iq_rs2_rdy_o, iq_rob_tag_o, iq_payload_o
   );

   modport master (
      output ren_valid_i, rs1_p_i, rs2_p_i, rd_new_p_i, rd_old_p_i, rd_alloc_i,
             rob_tag_i, payload_i, rob_ready_i, iq_ready_i, wb_valid_i, wb_preg_i,
             recover_i,
      input  ren_ready_o, rob_valid_o, rob_tag_o, rob_rd_new_p_o, rob_rd_old_p_o,
             rob_rd_alloc_o, iq_valid_o, iq_rs1_p_o, iq_rs2_p_o, iq_rd_p_o,
             iq_rs1_rdy_o, iq_rs2_rdy_o, iq_rob_tag_o, iq_payload_o
   );
endinterface

// File: rtl/dispatch_fifo.sv
// Small circular FIFO of dispatch entries with a synchronous flush; head is read combinationally.
module dispatch_fifo
   import dispatch_stage_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_flush,
   input  logic            i_push,
   input  dispatch_entry_t i_data,
   input  logic            i_pop,
   output dispatch_entry_t o_data,
   output logic            o_full,
   output logic            o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [AW:0]     r_count;
   dispatch_entry_t r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset: occupancy alone decides whether an entry is meaningful.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_tail] <= i_data;
   end

   assign o_data  = r_mem[r_head];
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: skid FIFO from Rename, lockstep ROB/IQ dispatch, preg busy table.
// Optional DISPATCH_STALL_CNT_EN adds saturating ROB/IQ back-pressure counters.
module dispatch_stage
   import dispatch_stage_pkg::*;
#(
   parameter int N_PHYS     = N_PHYS_DEF,
   parameter int ROB_TAG_W  = ENTRY_TAG_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   dispatch_stage_if.slave bus
`ifdef DISPATCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_rob_cnt_o,
   output logic [31:0] stall_iq_cnt_o
`endif
);
   localparam int PW = $clog2(N_PHYS);

   logic [N_PHYS-1:0]    r_busy;
   dispatch_entry_t      w_in;
   dispatch_entry_t      w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_head_v;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_fire;
   logic [PW-1:0]        w_rs1;
   logic [PW-1:0]        w_rs2;
   logic [ROB_TAG_W-1:0] w_tag;

   function automatic logic src_rdy(input logic [PW-1:0]     p,
                                    input logic [N_PHYS-1:0] busy,
                                    input logic              wbv,
                                    input logic [PW-1:0]     wbp);
      return (p == '0) || !busy[p] || (wbv && (wbp == p));
   endfunction

   always_comb begin
      w_in          = '0;
      w_in.rs1_p    = bus.rs1_p_i;
      w_in.rs2_p    = bus.rs2_p_i;
      w_in.rd_new_p = bus.rd_new_p_i;
      w_in.rd_old_p = bus.rd_old_p_i;
      w_in.rd_alloc = bus.rd_alloc_i;
      w_in.rob_tag  = bus.rob_tag_i;
      w_in.payload  = bus.payload_i;
   end

   // rst_n gating keeps ready low for the whole reset window, not just after it.
   assign w_ready  = rst_n && !w_full && !bus.recover_i;
   assign w_accept = bus.ren_valid_i && w_ready;
   assign w_head_v = !w_empty;
   assign w_fire   = w_head_v && bus.rob_ready_i && bus.iq_ready_i && !bus.recover_i;

   dispatch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_flush(bus.recover_i),
      .i_push (w_accept),
      .i_data (w_in),
      .i_pop  (w_fire),
      .o_data (w_head),
      .o_full (w_full),
      .o_empty(w_empty)
   );

   // Set is applied after clear so a same-edge allocation of a written-back preg stays busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         if (bus.wb_valid_i && bus.wb_preg_i != '0) r_busy[bus.wb_preg_i] <= 1'b0;
         if (w_accept && bus.rd_alloc_i && bus.rd_new_p_i != '0) r_busy[bus.rd_new_p_i] <= 1'b1;
      end
   end

   assign w_rs1 = w_head.rs1_p;
   assign w_rs2 = w_head.rs2_p;
   assign w_tag = w_head.rob_tag;

   assign bus.ren_ready_o    = w_ready;
   assign bus.rob_valid_o    = w_head_v && !bus.recover_i;
   assign bus.iq_valid_o     = w_head_v && !bus.recover_i;
   assign bus.rob_tag_o      = w_head_v ? w_tag : '0;
   assign bus.rob_rd_new_p_o = w_head_v ? w_head.rd_new_p : '0;
   assign bus.rob_rd_old_p_o = w_head_v ? w_head.rd_old_p : '0;
   assign bus.rob_rd_alloc_o = w_head_v && w_head.rd_alloc;
   assign bus.iq_rs1_p_o     = w_head_v ? w_rs1 : '0;
   assign bus.iq_rs2_p_o     = w_head_v ? w_rs2 : '0;
   assign bus.iq_rd_p_o      = w_head_v ? w_head.rd_new_p : '0;
   assign bus.iq_rob_tag_o   = w_head_v ? w_tag : '0;
   assign bus.iq_payload_o   = w_head_v ? w_head.payload : '0;
   assign bus.iq_rs1_rdy_o   = w_head_v && src_rdy(w_rs1, r_busy, bus.wb_valid_i, bus.wb_preg_i);
   assign bus.iq_rs2_rdy_o   = w_head_v && src_rdy(w_rs2, r_busy, bus.wb_valid_i, bus.wb_preg_i);

`ifdef DISPATCH_STALL_CNT_EN
   logic [31:0] r_stall_rob_cnt;
   logic [31:0] r_stall_iq_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_rob_cnt <= '0;
         r_stall_iq_cnt  <= '0;
      end else begin
         if (w_head_v && !bus.recover_i && !bus.rob_ready_i && r_stall_rob_cnt != '1)
            r_stall_rob_cnt <= r_stall_rob_cnt + 1'b1;
         if (w_head_v && !bus.recover_i && bus.rob_ready_i && !bus.iq_ready_i &&
             r_stall_iq_cnt != '1)
            r_stall_iq_cnt <= r_stall_iq_cnt + 1'b1;
      end
   end

   assign stall_rob_cnt_o = r_stall_rob_cnt;
   assign stall_iq_cnt_o  = r_stall_iq_cnt;
`endif
endmodule

// File: tb/tb_dispatch_stage.sv
// Scoreboard bench for dispatch_stage: directed scenarios plus a randomised back-pressure phase.
module tb_dispatch_stage;
   import dispatch_stage_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dispatch_stage_if #(.PW(6), .ROB_TAG_W(6)) bus ();

`ifdef DISPATCH_STALL_CNT_EN
   logic [31:0] stall_rob_cnt;
   logic [31:0] stall_iq_cnt;
`endif

   dispatch_stage #(.N_PHYS(64), .ROB_TAG_W(6), .FIFO_DEPTH(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
`ifdef DISPATCH_STALL_CNT_EN
      ,
      .stall_rob_cnt_o(stall_rob_cnt),
      .stall_iq_cnt_o (stall_iq_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: expected FIFO contents and busy table
   dispatch_entry_t sb_q[$];
   logic [63:0]     m_busy;
   dispatch_entry_t m_e;
   dispatch_entry_t m_new;
   logic            m_exp_v;
   logic            m_acc;
   logic            m_fire;

   function automatic logic exp_rdy(input logic [5:0] p);
      return (p == 6'd0) || !m_busy[p] || (bus.wb_valid_i && bus.wb_preg_i == p);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         m_busy = '0;
      end else begin
         m_exp_v = (sb_q.size() > 0) && !bus.recover_i;
         check("rob_valid", 64'(bus.rob_valid_o), 64'(m_exp_v));
         check("iq_valid", 64'(bus.iq_valid_o), 64'(m_exp_v));
         check("ren_ready", 64'(bus.ren_ready_o), 64'((sb_q.size() < 2) && !bus.recover_i));
         if (m_exp_v) begin
            m_e = sb_q[0];
            check("rob_tag", 64'(bus.rob_tag_o), 64'(m_e.rob_tag));
            check("iq_tag", 64'(bus.iq_rob_tag_o), 64'(m_e.rob_tag));
            check("rob_rd_new", 64'(bus.rob_rd_new_p_o), 64'(m_e.rd_new_p));
            check("rob_rd_old", 64'(bus.rob_rd_old_p_o), 64'(m_e.rd_old_p));
            check("rob_alloc", 64'(bus.rob_rd_alloc_o), 64'(m_e.rd_alloc));
            check("iq_rs1", 64'(bus.iq_rs1_p_o), 64'(m_e.rs1_p));
            check("iq_rs2", 64'(bus.iq_rs2_p_o), 64'(m_e.rs2_p));
            check("iq_rd", 64'(bus.iq_rd_p_o), 64'(m_e.rd_new_p));
            check("iq_payload", 64'(bus.iq_payload_o), 64'(m_e.payload));
            check("rs1_rdy", 64'(bus.iq_rs1_rdy_o), 64'(exp_rdy(m_e.rs1_p)));
            check("rs2_rdy", 64'(bus.iq_rs2_rdy_o), 64'(exp_rdy(m_e.rs2_p)));
         end
         m_fire = m_exp_v && bus.rob_ready_i && bus.iq_ready_i;
         m_acc  = bus.ren_valid_i && (sb_q.size() < 2) && !bus.recover_i;
         if (m_fire) void'(sb_q.pop_front());
         if (m_acc) begin
            m_new          = '0;
            m_new.rs1_p    = bus.rs1_p_i;
            m_new.rs2_p    = bus.rs2_p_i;
            m_new.rd_new_p = bus.rd_new_p_i;
            m_new.rd_old_p = bus.rd_old_p_i;
            m_new.rd_alloc = bus.rd_alloc_i;
            m_new.rob_tag  = bus.rob_tag_i;
            m_new.payload  = bus.payload_i;
            sb_q.push_back(m_new);
         end
         if (bus.recover_i) sb_q.delete();
         if (bus.wb_valid_i && bus.wb_preg_i != 6'd0) m_busy[bus.wb_preg_i] = 1'b0;
         if (m_acc && bus.rd_alloc_i && bus.rd_new_p_i != 6'd0) m_busy[bus.rd_new_p_i] = 1'b1;
      end
   end

   logic [5:0] tag_ctr = 6'd0;

   task automatic set_fields(input logic [5:0] rs1, input logic [5:0] rs2,
                             input logic [5:0] rd, input logic alloc);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      bus.rs1_p_i    = rs1;
      bus.rs2_p_i    = rs2;
      bus.rd_new_p_i = rd;
      bus.rd_alloc_i = alloc;
      bus.rd_old_p_i = 6'($urandom());
      bus.rob_tag_i  = tag_ctr;
      bus.payload_i  = 42'(r);
      tag_ctr        = tag_ctr + 6'd1;
   endtask

   task automatic push_uop(input logic [5:0] rs1, input logic [5:0] rs2,
                           input logic [5:0] rd, input logic alloc);
      int tries;
      logic acc;
      tries = 0;
      acc   = 1'b0;
      set_fields(rs1, rs2, rd, alloc);
      bus.ren_valid_i = 1'b1;
      while (!acc && tries < 40) begin
         @(negedge clk);
         acc = bus.ren_ready_o;
         @(posedge clk);
         #1;
         tries++;
      end
      bus.ren_valid_i = 1'b0;
      if (!acc) check("push_timeout", 64'(acc), 64'd1);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [5:0] tag_a;

   initial begin
      bus.ren_valid_i = 1'b0;
      bus.rob_ready_i = 1'b1;
      bus.iq_ready_i  = 1'b1;
      bus.wb_valid_i  = 1'b0;
      bus.wb_preg_i   = '0;
      bus.recover_i   = 1'b0;
      set_fields(6'd0, 6'd0, 6'd0, 1'b0);
      tag_ctr = 6'd0;

      #12;
      check("rst_ren_ready", 64'(bus.ren_ready_o), 64'd0);
      check("rst_rob_valid", 64'(bus.rob_valid_o), 64'd0);
      check("rst_iq_valid", 64'(bus.iq_valid_o), 64'd0);
      check("rst_iq_rs1", 64'(bus.iq_rs1_p_o), 64'd0);
      check("rst_rob_tag", 64'(bus.rob_tag_o), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      next_cycle();

      // T1: first uop appears one cycle after acceptance; rd 33 becomes busy
      push_uop(6'd5, 6'd0, 6'd33, 1'b1);
      @(negedge clk);
      check("t1_latency", 64'(bus.iq_valid_o), 64'd1);
      check("t1_rs1_rdy", 64'(bus.iq_rs1_rdy_o), 64'd1);
      check("t1_rs2_rdy", 64'(bus.iq_rs2_rdy_o), 64'd1);
      check("t1_rs1_p", 64'(bus.iq_rs1_p_o), 64'd5);
      next_cycle();
      push_uop(6'd33, 6'd0, 6'd0, 1'b0);
      @(negedge clk);
      check("t1_busy33", 64'(bus.iq_rs1_rdy_o), 64'd0);
      next_cycle();

      // T2: dependent uop sees busy source, then the writeback bypass
      push_uop(6'd0, 6'd0, 6'd40, 1'b1);
      push_uop(6'd40, 6'd0, 6'd0, 1'b0);
      @(negedge clk);
      check("t2_dep_p", 64'(bus.iq_rs1_p_o), 64'd40);
      check("t2_dep_busy", 64'(bus.iq_rs1_rdy_o), 64'd0);
      next_cycle();
      push_uop(6'd0, 6'd0, 6'd40, 1'b1);
      push_uop(6'd40, 6'd0, 6'd0, 1'b0);
      bus.wb_valid_i = 1'b1;
      bus.wb_preg_i  = 6'd40;
      @(negedge clk);
      check("t2_bypass", 64'(bus.iq_rs1_rdy_o), 64'd1);
      next_cycle();
      bus.wb_valid_i = 1'b0;

      // T3: ROB stall fills the FIFO, outputs hold, then drain in order
      bus.rob_ready_i = 1'b0;
      tag_a = tag_ctr;
      push_uop(6'd1, 6'd2, 6'd0, 1'b0);
      push_uop(6'd3, 6'd4, 6'd0, 1'b0);
      set_fields(6'd7, 6'd8, 6'd0, 1'b0);
      bus.ren_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_full_ready", 64'(bus.ren_ready_o), 64'd0);
         check("t3_hold_tag", 64'(bus.iq_rob_tag_o), 64'(tag_a));
         next_cycle();
      end
      bus.ren_valid_i = 1'b0;
      bus.rob_ready_i = 1'b1;
      @(negedge clk);
      check("t3_first", 64'(bus.iq_rob_tag_o), 64'(tag_a));
      next_cycle();
      @(negedge clk);
      check("t3_second", 64'(bus.iq_rob_tag_o), 64'(tag_a + 6'd1));
      next_cycle();
      @(negedge clk);
      check("t3_drained", 64'(bus.iq_valid_o), 64'd0);
      next_cycle();

      // T4: allocation and writeback of the same preg on one edge -> busy
      bus.wb_valid_i = 1'b1;
      bus.wb_preg_i  = 6'd45;
      push_uop(6'd0, 6'd0, 6'd45, 1'b1);
      bus.wb_valid_i = 1'b0;
      push_uop(6'd45, 6'd0, 6'd0, 1'b0);
      @(negedge clk);
      check("t4_set_wins", 64'(bus.iq_rs1_rdy_o), 64'd0);
      next_cycle();

      // T5: recovery with a full FIFO and a pending Rename uop
      bus.rob_ready_i = 1'b0;
      push_uop(6'd0, 6'd0, 6'd50, 1'b1);
      push_uop(6'd0, 6'd0, 6'd51, 1'b1);
      set_fields(6'd0, 6'd0, 6'd52, 1'b1);
      bus.ren_valid_i = 1'b1;
      bus.recover_i   = 1'b1;
      @(negedge clk);
      check("t5_ready_low", 64'(bus.ren_ready_o), 64'd0);
      check("t5_rob_valid", 64'(bus.rob_valid_o), 64'd0);
      check("t5_iq_valid", 64'(bus.iq_valid_o), 64'd0);
      next_cycle();
      bus.recover_i   = 1'b0;
      bus.ren_valid_i = 1'b0;
      bus.rob_ready_i = 1'b1;
      @(negedge clk);
      check("t5_empty", 64'(bus.iq_valid_o), 64'd0);
      check("t5_ready_back", 64'(bus.ren_ready_o), 64'd1);
      next_cycle();
      push_uop(6'd50, 6'd52, 6'd0, 1'b0);
      @(negedge clk);
      check("t5_busy_kept", 64'(bus.iq_rs1_rdy_o), 64'd0);
      check("t5_no_alloc", 64'(bus.iq_rs2_rdy_o), 64'd1);
      next_cycle();

      // T6: asynchronous reset in the middle of a stall
      bus.rob_ready_i = 1'b0;
      push_uop(6'd0, 6'd0, 6'd60, 1'b1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rob_valid", 64'(bus.rob_valid_o), 64'd0);
      check("t6_iq_valid", 64'(bus.iq_valid_o), 64'd0);
      check("t6_ren_ready", 64'(bus.ren_ready_o), 64'd0);
      check("t6_tag", 64'(bus.iq_rob_tag_o), 64'd0);
      check("t6_rd_new", 64'(bus.rob_rd_new_p_o), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      bus.rob_ready_i = 1'b1;
      next_cycle();
      push_uop(6'd60, 6'd33, 6'd0, 1'b0);
      @(negedge clk);
      check("t6_latency", 64'(bus.iq_valid_o), 64'd1);
      check("t6_rs1_clear", 64'(bus.iq_rs1_rdy_o), 64'd1);
      check("t6_rs2_clear", 64'(bus.iq_rs2_rdy_o), 64'd1);
      next_cycle();

      // Randomised traffic with back-pressure, writebacks and occasional recovery
      for (int i = 0; i < 300; i++) begin
         set_fields(6'($urandom()), 6'($urandom_range(0, 7)), 6'($urandom()), 1'($urandom()));
         bus.ren_valid_i = 1'($urandom());
         bus.rob_ready_i = ($urandom_range(0, 3) != 0);
         bus.iq_ready_i  = ($urandom_range(0, 3) != 0);
         bus.wb_valid_i  = 1'($urandom());
         bus.wb_preg_i   = 6'($urandom_range(0, 7));
         bus.recover_i   = ($urandom_range(0, 31) == 0);
         next_cycle();
      end
      bus.ren_valid_i = 1'b0;
      bus.rob_ready_i = 1'b1;
      bus.iq_ready_i  = 1'b1;
      bus.wb_valid_i  = 1'b0;
      bus.recover_i   = 1'b0;
      repeat (4) next_cycle();
      check("drain_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
